// File: rtl/muldiv_unit.sv
// Iterative multi-cycle multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, with a final sign-fix step and start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]         state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               neg_res;
  logic               neg_rem;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  assign abs_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // During RUN a_q/b_q hold magnitudes; acc is {partial product, multiplier}
  // for MUL and {partial remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : '0)};
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      acc         <= '0;
      count       <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q        <= op;
            a_q         <= a_in;
            b_q         <= b_in;
            div_by_zero <= 1'b0;
            state       <= S_PREP;
          end
        end
        S_PREP: begin
          neg_res <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= is_signed & a_q[WIDTH-1];
          a_q     <= abs_a;
          b_q     <= abs_b;
          acc     <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          count   <= CW'(WIDTH - 1);
          if (is_div && (b_q == '0)) begin
            lo_out      <= '1;
            hi_out      <= a_q;
            div_by_zero <= 1'b1;
            state       <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count - 1'b1;
          if (count == '0)
            state <= S_FIX;
        end
        S_FIX: begin
          hi_out <= fix_hi;
          lo_out <= fix_lo;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed test-plan vectors plus random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc_now = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Reference: {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p[63:0]}; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; return {1'b0, u}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issues one op; returns the cycle in which done was seen (cycle 1 = first
  // cycle after the sampling edge), the number of busy cycles up to it, and
  // div_by_zero in cycle 1. Optionally pulses a stray start in cycle poke.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int dcyc, output int bcnt, output logic dbz1);
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
    dcyc = 1; bcnt = 0; dbz1 = div_by_zero;
    while (1) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1 || dcyc >= 200) break;
      @(negedge clk);
      dcyc++;
      start = (dcyc == poke);
      if (start) begin op = 2'($urandom); a_in = $urandom; b_in = $urandom; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, hi_out, lo_out, div_by_zero} !== 67'b0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h dbz=%b, want all 0",
               busy, done, hi_out, lo_out, div_by_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_muls;
    int dc, bc; logic d1;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, dc, bc, d1);
    vectors++;
    if (dc !== 35) begin miscompares++; $display("FAIL muls_done_cycle: got %0d want 35", dc); end
    vectors++;
    if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      miscompares++; $display("FAIL muls_result: got %h_%h want ffffffff_ffffffeb", hi_out, lo_out);
    end
    vectors++;
    if (bc !== 35) begin miscompares++; $display("FAIL muls_busy_cycles: got %0d want 35", bc); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL muls_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int dc, bc, t1, t2; logic d1;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, dc, bc, d1);
    t1 = cyc_now;
    vectors++;
    if ({hi_out, lo_out} !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++; $display("FAIL mulu_max: got %h_%h want fffffffe_00000001", hi_out, lo_out);
    end
    run_op(2'b01, 32'd3, 32'd5, 0, dc, bc, d1);
    t2 = cyc_now;
    vectors++;
    if ({hi_out, lo_out} !== 64'd15) begin
      miscompares++; $display("FAIL mulu_3x5: got %h_%h want 0_f", hi_out, lo_out);
    end
    vectors++;
    if (t2 - t1 !== 36) begin miscompares++; $display("FAIL b2b_spacing: got %0d want 36", t2 - t1); end
  endtask

  task automatic test_divide;
    int dc, bc; logic d1;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, dc, bc, d1);
    vectors++;
    if ({div_by_zero, hi_out, lo_out} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}) begin
      miscompares++; $display("FAIL divs_neg7_2: got dbz=%b %h_%h want 0 ffffffff_fffffffd", div_by_zero, hi_out, lo_out);
    end
    run_op(2'b11, 32'd7, 32'd2, 0, dc, bc, d1);
    vectors++;
    if ({hi_out, lo_out} !== {32'd1, 32'd3}) begin
      miscompares++; $display("FAIL divu_7_2: got %h_%h want 1_3", hi_out, lo_out);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, dc, bc, d1);
    vectors++;
    if ({hi_out, lo_out} !== {32'd0, 32'h8000_0000}) begin
      miscompares++; $display("FAIL divs_min_neg1: got %h_%h want 0_80000000", hi_out, lo_out);
    end
  endtask

  task automatic test_div_by_zero;
    int dc, bc; logic d1;
    run_op(2'b11, 32'd100, 32'd0, 0, dc, bc, d1);
    vectors++;
    if (dc !== 2) begin miscompares++; $display("FAIL dbz_done_cycle: got %0d want 2", dc); end
    vectors++;
    if ({div_by_zero, hi_out, lo_out} !== {1'b1, 32'd100, 32'hFFFF_FFFF}) begin
      miscompares++; $display("FAIL dbz_result: got dbz=%b %h_%h want 1 00000064_ffffffff", div_by_zero, hi_out, lo_out);
    end
    run_op(2'b01, 32'd2, 32'd9, 0, dc, bc, d1);
    vectors++;
    if (d1 !== 1'b0) begin miscompares++; $display("FAIL dbz_cleared_on_start: got %b want 0", d1); end
  endtask

  task automatic test_random;
    int dc, bc; logic d1;
    logic [1:0] o; logic [31:0] a, b; logic [64:0] exp;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 9);
        default: ;
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, 0, dc, bc, d1);
      vectors++;
      if ({div_by_zero, hi_out, lo_out} !== exp) begin
        miscompares++;
        $display("FAIL rand_result[%0d] op=%b a=%h b=%h: got %b_%h_%h want %b_%h_%h", i, o, a, b,
                 div_by_zero, hi_out, lo_out, exp[64], exp[63:32], exp[31:0]);
      end
      vectors++;
      if (dc !== (exp[64] ? 2 : 35)) begin
        miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, dc, exp[64] ? 2 : 35);
      end
    end
  endtask

  task automatic test_start_ignored;
    int dc, bc; logic d1; logic [64:0] exp;
    exp = model(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
    run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 10, dc, bc, d1);
    vectors++;
    if (dc !== 35 || {hi_out, lo_out} !== exp[63:0]) begin
      miscompares++; $display("FAIL start_while_busy: got cyc=%0d %h_%h want cyc=35 %h_%h",
                              dc, hi_out, lo_out, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_clear;
    logic [31:0] hold_hi, hold_lo;
    int seen_done;
    hold_hi = hi_out; hold_lo = lo_out;
    @(negedge clk);
    op = 2'b01; a_in = 32'hDEAD_BEEF; b_in = 32'h0000_1001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy: got %b want 0", busy); end
    seen_done = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) seen_done++; end
    vectors++;
    if (seen_done !== 0) begin miscompares++; $display("FAIL clear_no_done: got %0d pulses want 0", seen_done); end
    vectors++;
    if ({hi_out, lo_out} !== {hold_hi, hold_lo}) begin
      miscompares++; $display("FAIL clear_hold: got %h_%h want %h_%h", hi_out, lo_out, hold_hi, hold_lo);
    end
    // clear and start together in IDLE: the start must be dropped
    op = 2'b01; a_in = 32'd4; b_in = 32'd4; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_beats_start: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    op = 2'b10; a_in = 32'hFFFF_0000; b_in = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({busy, done, hi_out, lo_out, div_by_zero} !== 67'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h dbz=%b want all 0",
               busy, done, hi_out, lo_out, div_by_zero);
    end
  endtask

  initial begin
    test_reset;
    test_muls;
    test_back_to_back;
    test_divide;
    test_div_by_zero;
    test_random;
    test_start_ignored;
    test_clear;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
